// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch: four 8-bit reads assembled big-endian.
// Optional misalignment trap enabled by defining FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_INSTR = 32'h00000000
) (
    input  logic        CLK_in,
    input  logic        Reset_in,
    input  logic        Req_in,
    input  logic [31:0] Address_in,
    output logic [31:0] Mem_addr_out,
    input  logic [7:0]  Mem_data_in,
    output logic [31:0] Instr_out,
    output logic        Valid_out,
    output logic        Busy_out,
    output logic        Halt_out,
    output logic        Error_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  idx;
    logic [31:0] base;
    logic [23:0] partial;
    logic        accept;
    logic        misalign;
    logic [31:0] req_base;

    assign req_base = {Address_in[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign = (Address_in[1:0] != 2'b00);

    // Flag a rejected misaligned request for exactly one cycle
    always_ff @(posedge CLK_in) begin
        if (Reset_in)
            Error_out <= 1'b0;
        else
            Error_out <= (state == IDLE) && Req_in && misalign;
    end
`else
    logic unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, Address_in[1:0]};
    assign misalign        = 1'b0;
    assign Error_out       = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK_in) begin
        if (Reset_in)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        Valid_out = 1'b0;
        Busy_out  = 1'b0;
        Halt_out  = 1'b1;
        unique case (state)
            IDLE: begin
                if (Req_in && !misalign) begin
                    accept    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                Busy_out = 1'b1;
                if (idx == 2'd3)
                    state_nxt = DONE;
            end
            DONE: begin
                Valid_out = 1'b1;
                Halt_out  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address sequencing and big-endian byte assembly
    always_ff @(posedge CLK_in) begin
        if (Reset_in) begin
            base         <= 32'h0;
            idx          <= 2'd0;
            Mem_addr_out <= 32'h0;
            partial      <= 24'h0;
            Instr_out    <= RESET_INSTR;
        end else if (accept) begin
            base         <= req_base;
            idx          <= 2'd0;
            Mem_addr_out <= req_base;
        end else if (state == FETCH) begin
            unique case (idx)
                2'd0: partial[23:16] <= Mem_data_in;
                2'd1: partial[15:8]  <= Mem_data_in;
                2'd2: partial[7:0]   <= Mem_data_in;
                2'd3: Instr_out      <= {partial, Mem_data_in};
                default: ;
            endcase
            if (idx == 2'd3) begin
                idx          <= 2'd0;
                Mem_addr_out <= base;
            end else begin
                idx          <= idx + 2'd1;
                Mem_addr_out <= base + {30'd0, idx} + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, corner
// sequences and random traffic against a transaction-level model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_W = 32'hDEADBEEF;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data;
    logic [31:0] instr;
    logic        valid;
    logic        busy;
    logic        halt;
    logic        err;

    int n_chk;
    int n_fail;

    // model: phase 0 idle, 1..4 reading byte phase-1, 5 done
    int          m_phase;
    logic [31:0] m_base;
    logic [31:0] m_instr;
    logic        m_err;

    instr_fetch_unit #(.RESET_INSTR(RST_W)) dut (
        .CLK_in       (clk),
        .Reset_in     (rst),
        .Req_in       (req),
        .Address_in   (addr),
        .Mem_addr_out (mem_addr),
        .Mem_data_in  (mem_data),
        .Instr_out    (instr),
        .Valid_out    (valid),
        .Busy_out     (busy),
        .Halt_out     (halt),
        .Error_out    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem(logic [31:0] a);
        if (a == 32'h10) return 8'h12;
        if (a == 32'h11) return 8'h34;
        if (a == 32'h12) return 8'h56;
        if (a == 32'h13) return 8'h78;
        return {a[4:0], a[7:5]} ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] word_at(logic [31:0] b);
        return {mem(b), mem(b + 32'd1), mem(b + 32'd2), mem(b + 32'd3)};
    endfunction

    always_comb mem_data = mem(mem_addr);

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h required=%h", n, $time, a, e);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_phase = 0;
            m_base  = 32'h0;
            m_instr = RST_W;
            m_err   = 1'b0;
        end else begin
            m_err = 1'b0;
            if (m_phase == 0) begin
                if (req) begin
                    if (ALIGN && addr[1:0] != 2'b00) begin
                        m_err = 1'b1;
                    end else begin
                        m_base  = addr & 32'hFFFF_FFFC;
                        m_phase = 1;
                    end
                end
            end else if (m_phase == 4) begin
                m_instr = word_at(m_base);
                m_phase = 5;
            end else if (m_phase == 5) begin
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] ea;
        ea = m_base;
        if (m_phase >= 1 && m_phase <= 4)
            ea = m_base + 32'(m_phase - 1);
        chk("mem_addr", mem_addr, ea);
        chk("instr", instr, m_instr);
        chk("valid", {31'd0, valid}, {31'd0, m_phase == 5});
        chk("busy", {31'd0, busy},
            {31'd0, m_phase >= 1 && m_phase <= 4});
        chk("halt", {31'd0, halt}, {31'd0, m_phase != 5});
        chk("error", {31'd0, err}, {31'd0, m_err});
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] w;
    } vec_t;

    vec_t vt[6];
    int   vcnt;
    int   last_v;
    int   hlo;

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        m_phase = 0;
        m_base  = 32'h0;
        m_instr = RST_W;
        m_err   = 1'b0;
        rst     = 1'b1;
        req     = 1'b1;
        addr    = 32'h0000_0040;

        vt[0] = '{32'h0000_0010, 32'h1234_5678};
        vt[1] = '{32'hFFFF_FFFC, word_at(32'hFFFF_FFFC)};
        vt[2] = '{32'h0000_0006, word_at(32'h0000_0004)};
        vt[3] = '{32'h0000_0200, word_at(32'h0000_0200)};
        vt[4] = '{32'h1234_567B, word_at(32'h1234_5678)};
        vt[5] = '{32'h8000_0000, word_at(32'h8000_0000)};

        // reset state, with a request held high during reset
        cyc();
        cyc();
        chk("rst_instr", instr, RST_W);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd1);
        chk("rst_addr", mem_addr, 32'd0);
        rst = 1'b0;
        req = 1'b0;
        cyc();

        // table-driven single fetches
        foreach (vt[i]) begin
            req  = 1'b1;
            addr = vt[i].a;
            cyc();
            req = 1'b0;
            for (int k = 0; k < 5; k++) begin
                cyc();
                if (k == 3)
                    chk("tbl_valid", {31'd0, valid},
                        {31'd0, !(ALIGN && vt[i].a[1:0] != 2'b00)});
            end
            if (!(ALIGN && vt[i].a[1:0] != 2'b00))
                chk("tbl_instr", instr, vt[i].w);
            cyc();
        end

        // back-to-back requests 0x0 then 0x4
        vcnt   = 0;
        last_v = 0;
        hlo    = 0;
        req    = 1'b1;
        addr   = 32'h0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 13) req = 1'b0;
            cyc();
            if (k == 1) addr = 32'h4;
            if (!halt) hlo++;
            if (valid) begin
                if (vcnt == 1)
                    chk("b2b_gap", 32'(k - last_v), 32'd6);
                vcnt++;
                last_v = k;
            end
        end
        chk("b2b_pulses", 32'(vcnt), 32'd2);
        chk("b2b_halt_lo", 32'(hlo), 32'd2);
        chk("b2b_instr", instr, word_at(32'h4));

        // reset during the third FETCH cycle
        req  = 1'b1;
        addr = 32'h20;
        cyc();
        req = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_valid", {31'd0, valid}, 32'd0);
        chk("mid_rst_instr", instr, RST_W);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        vcnt = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (valid) vcnt++;
        end
        chk("mid_rst_nopulse", 32'(vcnt), 32'd0);

        // address change during the second FETCH cycle
        req  = 1'b1;
        addr = 32'h40;
        cyc();
        req = 1'b0;
        cyc();
        addr = 32'h100;
        repeat (5) cyc();
        chk("addr_chg_instr", instr, word_at(32'h40));

        // random traffic
        for (int k = 0; k < 600; k++) begin
            rst  = ($urandom_range(0, 49) == 0);
            req  = $urandom_range(0, 1) == 1;
            addr = $urandom();
            if ($urandom_range(0, 7) == 0)
                addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            cyc();
        end

        rst = 1'b0;
        req = 1'b0;
        repeat (7) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_INSTR, default 32'h00000000, value loaded into Instr_out on reset.
REQ-002 CLK_in  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset_in  input  1  reset, synchronous, active-high.
REQ-004 Req_in  input  1  fetch request from the CPU side.
REQ-005 Address_in  input  32  byte address of the instruction; this is the program counter output.
REQ-006 Mem_addr_out  output  32  byte address to instruction memory, registered.
REQ-007 Mem_data_in  input  8  byte read from instruction memory, combinational read of Mem_addr_out.
REQ-008 Instr_out  output  32  last completed instruction word.
REQ-009 Valid_out  output  1  one-cycle pulse: Instr_out was just updated.
REQ-010 Busy_out  output  1  high while a fetch is in progress.
REQ-011 Halt_out  output  1  PC hold request, high in every state except DONE.
REQ-012 Error_out  output  1  misalignment pulse; tied 0 unless the alignment check is compiled in.

Function
REQ-013 FSM states: IDLE, FETCH, DONE; 2-bit byte index idx; 32-bit base register.
REQ-014 IDLE with Req_in=1 at an edge:
  - latch base = {Address_in[31:2],2'b00}
  - idx = 0
  - next state FETCH
  - Mem_addr_out = base
REQ-015 IDLE with Req_in=0: remain IDLE; all outputs hold.
REQ-016 FETCH, at each edge:
  - capture Mem_data_in into byte lane idx
  - Mem_addr_out = base+idx+1
  - idx increments
REQ-017 Byte order is big-endian: byte at base drives Instr_out[31:24]; byte at base+3 drives [7:0].
REQ-018 FETCH lasts exactly 4 cycles; on the edge capturing idx=3:
  - Instr_out updates to the assembled word
  - next state DONE
  - Mem_addr_out returns to base
REQ-019 DONE lasts exactly one cycle; Valid_out=1 only in DONE; next state IDLE unconditionally.
REQ-020 Req_in is ignored in FETCH and DONE; a new request is accepted no earlier than the first IDLE cycle after DONE.
REQ-021 Latency: request accepted at edge n; Valid_out high in the cycle after edge n+4; 6 cycles minimum per instruction.
REQ-022 Busy_out=1 exactly in FETCH.
REQ-023 Halt_out=0 exactly in DONE, so the PC advances once per completed fetch.
REQ-024 Address_in changes after acceptance do not affect the fetch in progress.
REQ-025 Address arithmetic is modulo 2^32:
  - base 32'hFFFFFFFC fetches bytes FFFFFFFC..FFFFFFFF
  - no carry beyond bit 31
REQ-026 Instr_out holds its value between completions, including across IDLE.

Reset
REQ-027 When Reset_in=1 at an edge:
  - state = IDLE, idx = 0, base = 0
  - Mem_addr_out = 0
  - Instr_out = RESET_INSTR
  - Valid_out = 0, Error_out = 0
REQ-028 Reset dominates Req_in and any in-progress FETCH or DONE: the partial word is discarded, no Valid_out pulse, Instr_out = RESET_INSTR.
REQ-029 While held in reset: Busy_out=0, Halt_out=1.

Configuration
REQ-030 Macro FETCH_ALIGN_CHECK_EN defined:
  - a request in IDLE with Address_in[1:0]!=0 does not enter FETCH
  - Error_out=1 for exactly the following cycle; state remains IDLE
  - Instr_out unchanged; Valid_out stays 0
REQ-031 FETCH_ALIGN_CHECK_EN undefined: Address_in[1:0] is ignored (forced to 00), and Error_out is constant 0.

Verification
REQ-032 Reset, then Req_in=1 with Address_in=0x00000010 and memory bytes 10..13 = 12,34,56,78:
  - Mem_addr_out sequence 10,11,12,13
  - Valid_out pulses after 5 edges
  - Instr_out=0x12345678
REQ-033 Back-to-back: Req_in held high at addresses 0x0 then 0x4:
  - exactly two Valid_out pulses, 6 cycles apart
  - Halt_out low only in the two DONE cycles
REQ-034 Reset_in=1 during the third FETCH cycle:
  - no Valid_out pulse
  - Instr_out=RESET_INSTR
  - state IDLE on the next cycle; Busy_out=0
REQ-035 Address_in=0xFFFFFFFC: Mem_addr_out FFFFFFFC..FFFFFFFF with no wrap into 0; word is assembled correctly.
REQ-036 Address_in=0x00000006:
  - with FETCH_ALIGN_CHECK_EN: Error_out one-cycle pulse, no memory sequence, Instr_out unchanged
  - without it: fetch from 0x00000004, Error_out=0
REQ-037 Address_in changed to 0x100 in the second FETCH cycle: fetch completes from the originally latched base.
